// File: rtl/ahb5_sram_slave_ctrl_if.sv
// AHB5 slave-port signal bundle between the interconnect and the SRAM controller.
interface ahb5_sram_slave_ctrl_if;
    logic        Hselx;
    logic [31:0] Haddr;
    logic        Hwrite;
    logic [2:0]  Hsize;
    logic [1:0]  Htrans;
    logic [2:0]  Hburst;
    logic [3:0]  Hprot;
    logic        Hmastlock;
    logic        Hready;
    logic [31:0] Hwdata;
    logic        Hreadyout;
    logic        Hresp;
    logic [31:0] Hrdata;

    modport slave (
        input  Hselx, Haddr, Hwrite, Hsize, Htrans, Hburst, Hprot, Hmastlock,
        input  Hready, Hwdata,
        output Hreadyout, Hresp, Hrdata
    );

    modport master (
        output Hselx, Haddr, Hwrite, Hsize, Htrans, Hburst, Hprot, Hmastlock,
        output Hwdata,
        input  Hready, Hreadyout, Hresp, Hrdata
    );
endinterface

// File: rtl/ahb5_sram_slave_ctrl.sv
// AHB5 slave controller for a single-port synchronous SRAM: address/data-phase
// pipelining, programmable wait states, write-commit vs. read arbitration on the
// one SRAM port, and the two-cycle ERROR response.
module ahb5_sram_slave_ctrl #(
    parameter int MEM_DEPTH   = 1024,
    parameter int AW          = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                 Hclk,
    input  logic                 HRESETn,
    ahb5_sram_slave_ctrl_if.slave ahb,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [3:0]           mem_be,
    output logic [AW-1:0]        mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata
);

    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic          rd_pend_reg, rd_pend_next;
    logic          dp_write_reg;
    logic [AW-1:0] dp_addr_reg;
    logic [3:0]    dp_be_reg;

    logic          can_accept, accept, addr_err, commit, rd_now, rd_delay;
    logic [3:0]    be;

    // Burst, protection and lock attributes carry no meaning for this slave.
    logic unused_attr;
    assign unused_attr = ^{ahb.Hburst, ahb.Hprot, ahb.Hmastlock, MEM_DEPTH[0]};

    // Address-phase decode: byte lanes and the illegal-access flag.
    always_comb begin
        be = 4'b1111;
        case (ahb.Hsize)
            3'd0:    be = 4'b0001 << ahb.Haddr[1:0];
            3'd1:    be = ahb.Haddr[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        addr_err = (ahb.Haddr[31:AW+2] != '0)
                 | (ahb.Hsize > 3'd2)
                 | ((ahb.Hsize == 3'd1) & ahb.Haddr[0])
                 | ((ahb.Hsize == 3'd2) & (ahb.Haddr[1:0] != 2'b00));
    end

    // A new address phase is only sampled while the data phase is not stalled.
    assign can_accept = (state_reg == IDLE) | (state_reg == DATA) | (state_reg == ERR2);
    assign accept     = can_accept & ahb.Hselx & ahb.Hready & ahb.Htrans[1];
    // The final cycle of an OKAY write data phase owns the SRAM port.
    assign commit     = (state_reg == DATA) & dp_write_reg;
    assign rd_now     = accept & ~ahb.Hwrite & ~addr_err & ~commit;
    assign rd_delay   = accept & ~ahb.Hwrite & ~addr_err & commit;

    // Next-state logic and wait-state counter.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        rd_pend_next = rd_pend_reg;
        case (state_reg)
            IDLE, DATA, ERR2: begin
                state_next   = IDLE;
                rd_pend_next = 1'b0;
                if (accept) begin
                    if (addr_err) begin
                        state_next = ERR1;
                    end else if ((WAIT_STATES > 0) || rd_delay) begin
                        state_next   = WAIT;
                        cnt_next     = WS + {3'b000, rd_delay} - 4'd1;
                        rd_pend_next = rd_delay;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            WAIT: begin
                rd_pend_next = 1'b0;
                if (cnt_reg == 4'd0) state_next = DATA;
                else                 cnt_next   = cnt_reg - 4'd1;
            end
            ERR1:    state_next = ERR2;
            default: state_next = IDLE;
        endcase
    end

    // State register and captured address phase; reset aborts any transfer.
    always_ff @(posedge Hclk or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            rd_pend_reg  <= 1'b0;
            dp_write_reg <= 1'b0;
            dp_addr_reg  <= '0;
            dp_be_reg    <= 4'd0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            rd_pend_reg <= rd_pend_next;
            if (accept) begin
                dp_write_reg <= ahb.Hwrite;
                dp_addr_reg  <= ahb.Haddr[AW+1:2];
                dp_be_reg    <= be;
            end
        end
    end

    assign ahb.Hreadyout = ~((state_reg == WAIT) | (state_reg == ERR1));
    assign ahb.Hresp     = (state_reg == ERR1) | (state_reg == ERR2);
    assign ahb.Hrdata    = ((state_reg == DATA) & ~dp_write_reg) ? mem_rdata : 32'h0;

    // SRAM port: write commit first, then a delayed read, then a fresh read.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (HRESETn) begin
            if (commit) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_be    = dp_be_reg;
                mem_addr  = dp_addr_reg;
                mem_wdata = ahb.Hwdata;
            end else if ((state_reg == WAIT) && rd_pend_reg) begin
                mem_en   = 1'b1;
                mem_be   = dp_be_reg;
                mem_addr = dp_addr_reg;
            end else if (rd_now) begin
                mem_en   = 1'b1;
                mem_be   = be;
                mem_addr = ahb.Haddr[AW+1:2];
            end
        end
    end

endmodule

// File: tb/tb_ahb5_sram_slave_ctrl.sv
// Bench for ahb5_sram_slave_ctrl: two instances (0 and 2 wait states), each with
// its own SRAM model, driven by a pipelined AHB master and a scoreboard queue.
module tb_ahb5_sram_slave_ctrl;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [1:0]  trans;
        bit          sel;
        int          exp_waits;
        bit          exp_resp;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_be;
    } xfer_t;

    logic Hclk = 1'b0;
    logic HRESETn = 1'b0;
    always #5 Hclk = ~Hclk;

    logic [1:0]        hselx_d, hwrite_d;
    logic [1:0][31:0]  haddr_d, hwdata_d;
    logic [1:0][2:0]   hsize_d;
    logic [1:0][1:0]   htrans_d;

    logic [1:0]        hreadyout_w, hresp_w, mem_en_w, mem_we_w;
    logic [1:0][31:0]  hrdata_w, mem_wdata_w;
    logic [1:0][3:0]   mem_be_w;
    logic [1:0][9:0]   mem_addr_w;

    logic [31:0] ref_mem [2][1024];
    xfer_t stim[$];
    xfer_t exp_q[$];
    int tests = 0;
    int fails = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        ahb5_sram_slave_ctrl_if bus ();
        logic [31:0] sram [1024];
        logic [31:0] sram_q;

        assign bus.Hselx     = hselx_d[gi];
        assign bus.Haddr     = haddr_d[gi];
        assign bus.Hwrite    = hwrite_d[gi];
        assign bus.Hsize     = hsize_d[gi];
        assign bus.Htrans    = htrans_d[gi];
        assign bus.Hburst    = 3'b000;
        assign bus.Hprot     = 4'b0011;
        assign bus.Hmastlock = 1'b0;
        assign bus.Hwdata    = hwdata_d[gi];
        assign bus.Hready    = bus.Hreadyout;
        assign hreadyout_w[gi] = bus.Hreadyout;
        assign hresp_w[gi]     = bus.Hresp;
        assign hrdata_w[gi]    = bus.Hrdata;

        ahb5_sram_slave_ctrl #(
            .MEM_DEPTH  (1024),
            .AW         (10),
            .WAIT_STATES(gi * 2)
        ) u_dut (
            .Hclk     (Hclk),
            .HRESETn  (HRESETn),
            .ahb      (bus),
            .mem_en   (mem_en_w[gi]),
            .mem_we   (mem_we_w[gi]),
            .mem_be   (mem_be_w[gi]),
            .mem_addr (mem_addr_w[gi]),
            .mem_wdata(mem_wdata_w[gi]),
            .mem_rdata(sram_q)
        );

        initial begin
            for (int i = 0; i < 1024; i++) sram[i] = 32'h0;
        end

        // Synchronous SRAM model: read data held until the next enabled read.
        always @(posedge Hclk) begin
            if (mem_en_w[gi]) begin
                if (mem_we_w[gi]) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be_w[gi][b]) sram[mem_addr_w[gi]][8*b +: 8] <= mem_wdata_w[gi][8*b +: 8];
                end else begin
                    sram_q <= sram[mem_addr_w[gi]];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int d);
        hselx_d[d]  = 1'b0;
        haddr_d[d]  = 32'h0;
        hwrite_d[d] = 1'b0;
        hsize_d[d]  = 3'd0;
        htrans_d[d] = 2'd0;
        hwdata_d[d] = 32'h0;
    endtask

    // Queue one transfer; expected read data comes from the bench memory model.
    task automatic push(input int d, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic [1:0] trans, input bit sel,
                        input int ew, input bit er, input logic [3:0] ebe);
        xfer_t x;
        x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata; x.trans = trans; x.sel = sel;
        x.exp_waits = ew; x.exp_resp = er; x.exp_be = ebe; x.exp_rdata = 32'h0;
        if (sel && trans[1] && !er) begin
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (ebe[b]) ref_mem[d][addr[11:2]][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                x.exp_rdata = ref_mem[d][addr[11:2]];
            end
        end
        stim.push_back(x);
    endtask

    // Pipelined master: address phase of the next item overlaps the current data phase.
    task automatic run_seq(input int d);
        xfer_t x, dp, e;
        bit dp_v = 1'b0;
        int waits = 0;
        int cyc = 0;
        while ((stim.size() > 0 || dp_v) && cyc < 500) begin
            cyc++;
            if (stim.size() > 0) begin
                x = stim[0];
                hselx_d[d] = x.sel; haddr_d[d] = x.addr; hwrite_d[d] = x.wr;
                hsize_d[d] = x.size; htrans_d[d] = x.trans;
            end else begin
                hselx_d[d] = 1'b0; htrans_d[d] = 2'd0; haddr_d[d] = 32'h0; hwrite_d[d] = 1'b0;
            end
            hwdata_d[d] = (dp_v && dp.wr) ? dp.wdata : 32'h0;
            @(negedge Hclk);
            if (stim.size() > 0 && hreadyout_w[d] && !(x.sel && x.trans[1]) && !(dp_v && dp.wr && !dp.exp_resp))
                chk("noaccept_mem_en", 32'(mem_en_w[d]), 32'h0);
            if (dp_v) begin
                if (!hreadyout_w[d]) begin
                    waits++;
                    if (dp.exp_resp) begin
                        chk("err1_hresp", 32'(hresp_w[d]), 32'h1);
                        chk("err1_mem_en", 32'(mem_en_w[d]), 32'h0);
                    end
                    if (waits > 16) begin
                        chk("wait_timeout", 32'(waits), 32'(dp.exp_waits));
                        void'(exp_q.pop_front());
                        dp_v = 1'b0;
                    end
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] dut%0d %s addr=0x%08h trans=%0d sel=%0d waits=%0d hresp=%0d hrdata=0x%08h",
                             d, e.wr ? "WR" : "RD", e.addr, e.trans, e.sel, waits, hresp_w[d], hrdata_w[d]);
                    chk("waits", 32'(waits), 32'(e.exp_waits));
                    chk("hresp", 32'(hresp_w[d]), 32'(e.exp_resp));
                    if (e.sel && e.trans[1] && !e.wr && !e.exp_resp)
                        chk("hrdata", hrdata_w[d], e.exp_rdata);
                    else
                        chk("hrdata_zero", hrdata_w[d], 32'h0);
                    if (e.sel && e.trans[1] && e.wr && !e.exp_resp) begin
                        chk("wr_mem_en", 32'(mem_en_w[d]), 32'h1);
                        chk("wr_mem_we", 32'(mem_we_w[d]), 32'h1);
                        chk("wr_mem_be", 32'(mem_be_w[d]), 32'(e.exp_be));
                        chk("wr_mem_addr", 32'(mem_addr_w[d]), 32'(e.addr[11:2]));
                        chk("wr_mem_wdata", mem_wdata_w[d], e.wdata);
                    end
                    if (e.exp_resp) chk("err2_mem_we", 32'(mem_we_w[d]), 32'h0);
                    dp_v = 1'b0;
                end
            end
            if (hreadyout_w[d] && stim.size() > 0) begin
                x = stim.pop_front();
                exp_q.push_back(x);
                dp = x;
                dp_v = 1'b1;
                waits = 0;
            end
            @(posedge Hclk); #1;
        end
        chk("seq_complete", 32'(stim.size() + exp_q.size()), 32'h0);
        stim.delete();
        exp_q.delete();
        idle(d);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 1024; i++) ref_mem[d][i] = 32'h0;
            idle(d);
        end

        // Reset held with random bus activity.
        HRESETn = 1'b0;
        repeat (6) begin
            @(posedge Hclk); #1;
            for (int d = 0; d < 2; d++) begin
                hselx_d[d]  = 1'b1;
                haddr_d[d]  = $urandom_range(0, 255) << 2;
                hwrite_d[d] = 1'($urandom_range(0, 1));
                hsize_d[d]  = 3'd2;
                htrans_d[d] = 2'($urandom_range(0, 3));
                hwdata_d[d] = $urandom();
            end
            @(negedge Hclk);
            for (int d = 0; d < 2; d++) begin
                chk("rst_hreadyout", 32'(hreadyout_w[d]), 32'h1);
                chk("rst_hresp", 32'(hresp_w[d]), 32'h0);
                chk("rst_hrdata", hrdata_w[d], 32'h0);
                chk("rst_mem_en", 32'(mem_en_w[d]), 32'h0);
            end
        end
        idle(0); idle(1);
        @(negedge Hclk);
        HRESETn = 1'b1;
        @(posedge Hclk); #1;

        // Zero wait states: write then read-after-write collision (one extra wait).
        push(0, 1, 32'h10, 3'd2, 32'hDEADBEEF, 2'd2, 1, 0, 0, 4'b1111);
        push(0, 0, 32'h10, 3'd2, 32'h0,        2'd2, 1, 1, 0, 4'b0000);
        run_seq(0);

        // Back-to-back word/byte/half writes, then a word read of the merged lanes.
        push(0, 1, 32'h20, 3'd2, 32'h11223344, 2'd2, 1, 0, 0, 4'b1111);
        push(0, 1, 32'h21, 3'd0, 32'h0000AB00, 2'd3, 1, 0, 0, 4'b0010);
        push(0, 0, 32'h20, 3'd2, 32'h0,        2'd3, 1, 1, 0, 4'b0000);
        push(0, 1, 32'h22, 3'd1, 32'h55660000, 2'd2, 1, 0, 0, 4'b1100);
        push(0, 0, 32'h20, 3'd2, 32'h0,        2'd2, 1, 1, 0, 4'b0000);
        run_seq(0);

        // Read followed by write does not stall; read of untouched-by-collision word.
        push(0, 0, 32'h10, 3'd2, 32'h0,        2'd2, 1, 0, 0, 4'b0000);
        push(0, 1, 32'h14, 3'd2, 32'hA5A5C3C3, 2'd2, 1, 0, 0, 4'b1111);
        push(0, 0, 32'h14, 3'd2, 32'h0,        2'd2, 1, 1, 0, 4'b0000);
        run_seq(0);

        // Illegal accesses: two-cycle ERROR, then a read accepted during ERR2.
        push(0, 0, 32'h1002, 3'd2, 32'h0,      2'd2, 1, 1, 1, 4'b0000);
        push(0, 1, 32'h1000, 3'd2, 32'h12345678, 2'd2, 1, 1, 1, 4'b0000);
        push(0, 0, 32'h11,   3'd1, 32'h0,      2'd2, 1, 1, 1, 4'b0000);
        push(0, 0, 32'h10,   3'd3, 32'h0,      2'd2, 1, 1, 1, 4'b0000);
        push(0, 0, 32'h20,   3'd2, 32'h0,      2'd2, 1, 0, 0, 4'b0000);
        run_seq(0);

        // BUSY and unselected transfers: zero-wait OKAY, no SRAM activity.
        push(0, 0, 32'h10, 3'd2, 32'h0, 2'd1, 1, 0, 0, 4'b0000);
        push(0, 1, 32'h14, 3'd2, 32'hFFFFFFFF, 2'd2, 0, 0, 0, 4'b0000);
        push(0, 0, 32'h14, 3'd2, 32'h0, 2'd0, 1, 0, 0, 4'b0000);
        run_seq(0);

        // Two wait states: write, colliding read, then an isolated read.
        push(1, 1, 32'h40, 3'd2, 32'hCAFEF00D, 2'd2, 1, 2, 0, 4'b1111);
        push(1, 0, 32'h40, 3'd2, 32'h0,        2'd2, 1, 3, 0, 4'b0000);
        run_seq(1);
        push(1, 0, 32'h40, 3'd2, 32'h0,        2'd2, 1, 2, 0, 4'b0000);
        run_seq(1);

        // Reset pulsed during the wait states of a write: no SRAM write may occur.
        hselx_d[1] = 1'b1; haddr_d[1] = 32'h80; hwrite_d[1] = 1'b1;
        hsize_d[1] = 3'd2; htrans_d[1] = 2'd2;
        @(posedge Hclk); #1;
        idle(1);
        hwdata_d[1] = 32'h12345678;
        @(negedge Hclk);
        chk("rstwait_in_wait", 32'(hreadyout_w[1]), 32'h0);
        HRESETn = 1'b0;
        #1;
        chk("rstwait_hreadyout", 32'(hreadyout_w[1]), 32'h1);
        chk("rstwait_mem_en", 32'(mem_en_w[1]), 32'h0);
        repeat (3) begin
            @(negedge Hclk);
            chk("rstwait_no_we", 32'(mem_we_w[1]), 32'h0);
        end
        HRESETn = 1'b1;
        repeat (3) begin
            @(negedge Hclk);
            chk("rstwait_after_mem_en", 32'(mem_en_w[1]), 32'h0);
            chk("rstwait_after_rdy", 32'(hreadyout_w[1]), 32'h1);
        end
        @(posedge Hclk); #1;
        push(1, 0, 32'h80, 3'd2, 32'h0, 2'd2, 1, 2, 0, 4'b0000);
        run_seq(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
